i2c_master_pu: RTL and testbench

Byte-level I2C master that issues single-byte write or single-byte read transactions to a 7-bit addressed slave over an open-drain SCL/SDA pair. It is the initiator counterpart of the power-unit I2C slave model. It sits between the board-control register logic, which issues one command at a time, and the I2C pad drivers. It is also used in benches to drive the one-byte memory slave.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_master_qtick.sv | 43 ++++
 rtl/i2c_master_pu.sv | 145 ++++++++++++++
 tb/tb_i2c_master_pu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WR_BYTE  = 4'd4,
        ST_WR_ACK   = 4'd5,
        ST_RD_BYTE  = 4'd6,
        ST_RD_NACK  = 4'd7,
        ST_STOP     = 4'd8,
        ST_DONE     = 4'd9
    } i2c_mst_state_t;

    typedef logic [1:0] i2c_qtr_t;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_master_qtick.sv
// SCL quarter-period generator: a divider that pulses on the last cycle of each
// quarter and tracks the quarter index; it freezes while a slave stretches SCL.
module i2c_master_qtick
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_hold,
    output logic       o_qtick,
    output logic [1:0] o_qtr
);

    localparam int QW = $clog2(CLK_DIV);
    localparam logic [QW-1:0] QCNT_MAX = QW'(CLK_DIV - 1);

    logic [QW-1:0] r_qcnt;
    i2c_qtr_t      r_qtr;

    assign o_qtick = i_en && !i_hold && (r_qcnt == QCNT_MAX);
    assign o_qtr   = r_qtr;

    // Disabled means idle: both counters park at zero so a new transfer starts on Q0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_qcnt <= '0;
            r_qtr  <= '0;
        end else if (!i_en) begin
            r_qcnt <= '0;
            r_qtr  <= '0;
        end else if (!i_hold) begin
            if (r_qcnt == QCNT_MAX) begin
                r_qcnt <= '0;
                r_qtr  <= r_qtr + 2'd1;
            end else begin
                r_qcnt <= r_qcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_master_pu.sv
// Byte-level I2C master: one single-byte read or write per command to a 7-bit
// addressed slave, open-drain SCL/SDA (0 = pull low, 1 = release).
module i2c_master_pu
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CMD_VLD,
    output logic       CMD_RDY,
    input  logic       CMD_RW,
    input  logic [6:0] CMD_ADR,
    input  logic [7:0] CMD_DATA,
    output logic       RSP_VLD,
    output logic [7:0] RSP_DATA,
    output logic       RSP_NACK,
    output logic       BUSY,
    input  logic       SCL_i,
    output logic       SCL_o,
    input  logic       SDA_i,
    output logic       SDA_o,
    output logic [3:0] DBG_STATE
);

    // Handshake: a command transfers on a cycle with CMD_VLD && CMD_RDY; CMD_RDY is
    // high only in IDLE. The response is a single RSP_VLD pulse with no back-pressure.
    i2c_mst_state_t r_state, w_next;
    logic [7:0]     r_shift, r_data, r_rsp_data;
    logic [2:0]     r_bitcnt;
    logic           r_rw, r_nack;
    logic           w_accept, w_en, w_hold, w_qtick, w_end_q1, w_end_q3;
    logic           w_scl, w_sda, w_scl_bit;
    logic [1:0]     w_qtr;

    assign w_accept  = CMD_VLD && (r_state == ST_IDLE);
    assign w_en      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_hold    = w_scl && !SCL_i;
    assign w_end_q1  = w_qtick && (w_qtr == 2'd1);
    assign w_end_q3  = w_qtick && (w_qtr == 2'd3);
    assign w_scl_bit = w_qtr[0] ^ w_qtr[1];

    i2c_master_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_en    (w_en),
        .i_hold  (w_hold),
        .o_qtick (w_qtick),
        .o_qtr   (w_qtr)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next = ST_START;
            ST_START:    if (w_end_q3) w_next = ST_ADDR;
            ST_ADDR:     if (w_end_q3 && r_bitcnt == 3'd0) w_next = ST_ADDR_ACK;
            ST_ADDR_ACK: if (w_end_q3) w_next = r_nack ? ST_STOP :
                                                (r_rw == I2C_RD) ? ST_RD_BYTE : ST_WR_BYTE;
            ST_WR_BYTE:  if (w_end_q3 && r_bitcnt == 3'd0) w_next = ST_WR_ACK;
            ST_WR_ACK:   if (w_end_q3) w_next = ST_STOP;
            ST_RD_BYTE:  if (w_end_q3 && r_bitcnt == 3'd0) w_next = ST_RD_NACK;
            ST_RD_NACK:  if (w_end_q3) w_next = ST_STOP;
            ST_STOP:     if (w_end_q3) w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Line levels depend only on registered state, so SDA moves with the Q0 boundary.
    always_comb begin
        w_scl = 1'b1;
        w_sda = 1'b1;
        case (r_state)
            ST_START: begin
                w_sda = (w_qtr == 2'd0);
                w_scl = (w_qtr != 2'd3);
            end
            ST_ADDR, ST_WR_BYTE: begin
                w_scl = w_scl_bit;
                w_sda = r_shift[7];
            end
            ST_ADDR_ACK, ST_WR_ACK, ST_RD_BYTE, ST_RD_NACK: w_scl = w_scl_bit;
            ST_STOP: begin
                w_sda = w_qtr[1];
                w_scl = (w_qtr != 2'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shift    <= 8'h00;
            r_data     <= 8'h00;
            r_rsp_data <= 8'h00;
            r_bitcnt   <= 3'd7;
            r_rw       <= I2C_WR;
            r_nack     <= 1'b0;
        end else if (w_accept) begin
            r_rw     <= CMD_RW;
            r_data   <= CMD_DATA;
            r_shift  <= {CMD_ADR, CMD_RW};
            r_nack   <= 1'b0;
            r_bitcnt <= 3'd7;
        end else begin
            case (r_state)
                ST_ADDR, ST_WR_BYTE: if (w_end_q3) begin
                    r_shift  <= {r_shift[6:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 3'd1;
                end
                ST_ADDR_ACK: begin
                    if (w_end_q1 && SDA_i) r_nack <= 1'b1;
                    if (w_end_q3) begin
                        r_shift  <= r_data;
                        r_bitcnt <= 3'd7;
                    end
                end
                ST_WR_ACK: if (w_end_q1 && SDA_i) r_nack <= 1'b1;
                ST_RD_BYTE: begin
                    if (w_end_q1) r_shift  <= {r_shift[6:0], SDA_i};
                    if (w_end_q3) r_bitcnt <= r_bitcnt - 3'd1;
                end
                // Read data is published only for a completed, acknowledged read.
                ST_STOP: if (w_end_q3 && r_rw == I2C_RD && !r_nack) r_rsp_data <= r_shift;
                default: ;
            endcase
        end
    end

    assign SCL_o     = w_scl;
    assign SDA_o     = w_sda;
    assign CMD_RDY   = (r_state == ST_IDLE);
    assign BUSY      = (r_state != ST_IDLE);
    assign RSP_VLD   = (r_state == ST_DONE);
    assign RSP_NACK  = r_nack;
    assign RSP_DATA  = r_rsp_data;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_i2c_master_pu.sv
// Bench for i2c_master_pu: one-byte memory slave at 0x2A on an open-drain bus,
// table of read/write transactions plus stretch, busy and mid-transfer reset cases.
module tb_i2c_master_pu;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;

    logic       CLK, RST_N;
    logic       CMD_VLD, CMD_RDY, CMD_RW;
    logic [6:0] CMD_ADR;
    logic [7:0] CMD_DATA, RSP_DATA;
    logic       RSP_VLD, RSP_NACK, BUSY;
    logic       SCL_o, SDA_o;
    logic [3:0] DBG_STATE;
    logic       scl_hold, s_sda;
    logic       scl_bus, sda_bus;

    assign scl_bus = SCL_o & scl_hold;
    assign sda_bus = SDA_o & s_sda;

    i2c_master_pu #(.CLK_DIV(CLK_DIV)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VLD(CMD_VLD), .CMD_RDY(CMD_RDY), .CMD_RW(CMD_RW),
        .CMD_ADR(CMD_ADR), .CMD_DATA(CMD_DATA),
        .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .RSP_NACK(RSP_NACK), .BUSY(BUSY),
        .SCL_i(scl_bus), .SCL_o(SCL_o), .SDA_i(sda_bus), .SDA_o(SDA_o),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory slave model ----------------
    logic       p_scl, p_sda, s_rw;
    int         s_phase, s_cnt;
    logic [7:0] s_shift, s_mem;
    int         stop_cnt = 0;
    int         rsp_cnt = 0;

    always @(posedge CLK) if (RSP_VLD) rsp_cnt++;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_scl <= 1'b1; p_sda <= 1'b1; s_phase <= 0; s_cnt <= 0;
            s_shift <= 8'h00; s_mem <= 8'hBC; s_rw <= 1'b0; s_sda <= 1'b1;
        end else begin
            p_scl <= scl_bus;
            p_sda <= sda_bus;
            if (p_scl && scl_bus && p_sda && !sda_bus) begin
                s_phase <= 1; s_cnt <= -1; s_sda <= 1'b1;
            end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
                s_phase <= 0; s_sda <= 1'b1; stop_cnt <= stop_cnt + 1;
            end else if (!p_scl && scl_bus) begin
                if ((s_phase == 1 || s_phase == 2) && s_cnt >= 0 && s_cnt < 8)
                    s_shift <= {s_shift[6:0], sda_bus};
            end else if (p_scl && !scl_bus) begin
                case (s_phase)
                    1: if (s_cnt < 7) s_cnt <= s_cnt + 1;
                       else if (s_cnt == 7) begin
                           s_cnt <= 8;
                           if (s_shift[7:1] == 7'h2A) begin s_sda <= 1'b0; s_rw <= s_shift[0]; end
                           else s_phase <= 4;
                       end else begin
                           s_cnt <= 0;
                           if (s_rw) begin s_phase <= 3; s_sda <= s_mem[7]; end
                           else begin s_phase <= 2; s_sda <= 1'b1; end
                       end
                    2: if (s_cnt < 7) s_cnt <= s_cnt + 1;
                       else if (s_cnt == 7) begin s_cnt <= 8; s_mem <= s_shift; s_sda <= 1'b0; end
                       else begin s_sda <= 1'b1; s_phase <= 4; end
                    3: if (s_cnt < 7) begin s_cnt <= s_cnt + 1; s_sda <= s_mem[6 - s_cnt]; end
                       else if (s_cnt == 7) begin s_cnt <= 8; s_sda <= 1'b1; end
                       else s_phase <= 4;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_cmd(input logic rw, input logic [6:0] adr, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic nk);
        int waits = 0;
        @(negedge CLK);
        while (!CMD_RDY && waits < 1000) begin @(negedge CLK); waits++; end
        if (!CMD_RDY) check("cmd_rdy_timeout", 0, 1);
        CMD_VLD = 1'b1; CMD_RW = rw; CMD_ADR = adr; CMD_DATA = wd;
        lat = 0;
        do begin
            @(negedge CLK);
            if (lat == 0) CMD_VLD = 1'b0;
            lat++;
        end while (!RSP_VLD && lat < 2000);
        rd = RSP_DATA;
        nk = RSP_NACK;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] adr;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       exp_nack;
        int         exp_lat;
    } vec_t;

    vec_t       vecs[7];
    int         lat, stops0, rsp0, waits;
    logic [7:0] rd;
    logic       nk;

    initial begin
        vecs[0] = '{I2C_RD, 7'h2A, 8'h00, 8'hBC, 1'b0, 321};
        vecs[1] = '{I2C_WR, 7'h2A, 8'h5A, 8'hBC, 1'b0, 321};
        vecs[2] = '{I2C_RD, 7'h2A, 8'h00, 8'h5A, 1'b0, 321};
        vecs[3] = '{I2C_RD, 7'h11, 8'h00, 8'h5A, 1'b1, 177};
        vecs[4] = '{I2C_WR, 7'h11, 8'h33, 8'h5A, 1'b1, 177};
        vecs[5] = '{I2C_WR, 7'h2A, 8'hC3, 8'h5A, 1'b0, 321};
        vecs[6] = '{I2C_RD, 7'h2A, 8'h00, 8'hC3, 1'b0, 321};

        RST_N = 1'b0; CMD_VLD = 1'b0; CMD_RW = I2C_WR; CMD_ADR = 7'h00; CMD_DATA = 8'h00;
        scl_hold = 1'b1;
        #12;
        check("rst_scl_o", SCL_o, 1);
        check("rst_sda_o", SDA_o, 1);
        check("rst_cmd_rdy", CMD_RDY, 1);
        check("rst_busy", BUSY, 0);
        check("rst_rsp_vld", RSP_VLD, 0);
        check("rst_rsp_nack", RSP_NACK, 0);
        check("rst_rsp_data", RSP_DATA, 8'h00);
        check("rst_state", DBG_STATE, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            stops0 = stop_cnt;
            exp_q.push_back(vecs[i].exp_data);
            do_cmd(vecs[i].rw, vecs[i].adr, vecs[i].wdata, lat, rd, nk);
            check($sformatf("vec%0d_data", i), rd, exp_q.pop_front());
            check($sformatf("vec%0d_nack", i), nk, vecs[i].exp_nack);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_stop_seen", i), stop_cnt, stops0 + 1);
            check($sformatf("vec%0d_lines_released", i), {SCL_o, SDA_o}, 2'b11);
        end

        // Slave stretches SCL for 37 cycles in the address ACK slot.
        fork
            do_cmd(I2C_RD, 7'h2A, 8'h00, lat, rd, nk);
            begin
                repeat (147) @(negedge CLK);
                scl_hold = 1'b0;
                waits = 0;
                while (!SCL_o && waits < 50) begin @(negedge CLK); waits++; end
                repeat (37) @(negedge CLK);
                scl_hold = 1'b1;
            end
        join
        check("stretch_latency", lat, 321 + 37);
        check("stretch_data", rd, 8'hC3);
        check("stretch_nack", nk, 0);

        // CMD_VLD held high across two back-to-back commands.
        @(negedge CLK);
        CMD_VLD = 1'b1; CMD_RW = I2C_RD; CMD_ADR = 7'h2A; CMD_DATA = 8'h00;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (lat == 100) begin
                check("busy_mid_rdy", CMD_RDY, 0);
                check("busy_mid_busy", BUSY, 1);
            end
        end while (!RSP_VLD && lat < 2000);
        check("busy_first_latency", lat, 321);
        check("busy_first_data", RSP_DATA, 8'hC3);
        check("busy_rdy_at_rsp", CMD_RDY, 0);
        CMD_RW = I2C_WR; CMD_DATA = 8'h77;
        @(negedge CLK);
        check("busy_rdy_after_rsp", CMD_RDY, 1);
        check("busy_idle_after_rsp", BUSY, 0);
        lat = 0;
        do begin
            @(negedge CLK);
            if (lat == 0) begin
                check("busy_second_accepted", BUSY, 1);
                CMD_VLD = 1'b0;
            end
            lat++;
        end while (!RSP_VLD && lat < 2000);
        check("busy_second_latency", lat, 321);
        check("busy_second_nack", RSP_NACK, 0);
        do_cmd(I2C_RD, 7'h2A, 8'h00, lat, rd, nk);
        check("busy_readback", rd, 8'h77);

        // Reset dropped while the data byte is being read.
        @(negedge CLK);
        CMD_VLD = 1'b1; CMD_RW = I2C_RD; CMD_ADR = 7'h2A;
        @(negedge CLK);
        CMD_VLD = 1'b0;
        waits = 0;
        while (DBG_STATE != 4'd6 && waits < 1000) begin @(negedge CLK); waits++; end
        check("mid_reached_rd_byte", DBG_STATE, 6);
        repeat (5) @(negedge CLK);
        rsp0 = rsp_cnt;
        #1 RST_N = 1'b0;
        #1;
        check("mid_rst_scl_o", SCL_o, 1);
        check("mid_rst_sda_o", SDA_o, 1);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_cmd_rdy", CMD_RDY, 1);
        check("mid_rst_rsp_vld", RSP_VLD, 0);
        check("mid_rst_rsp_data", RSP_DATA, 8'h00);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (400) @(negedge CLK);
        check("mid_rst_no_rsp", rsp_cnt, rsp0);
        do_cmd(I2C_RD, 7'h2A, 8'h00, lat, rd, nk);
        check("post_rst_read_data", rd, 8'hBC);
        check("post_rst_read_latency", lat, 321);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
